trivium_wide: RTL and testbench
===============================

TRIVIUM_WIDE -- requirements
Module: trivium_wide

Interface
REQ-001 Parameter OUT_W, default 8, keystream bits produced per cycle; legal values are 1 to 64 inclusive.
REQ-002 Parameter INIT_ROUNDS, default 1152, initialisation clocks in bits; it SHALL be a multiple of OUT_W, checked at elaboration.
REQ-003 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port key_i, input, 80 bits: key; key_i[i] = K(i+1).
REQ-006 Port iv_i, input, 80 bits: IV; iv_i[i] = IV(i+1).
REQ-007 Port load_valid, input, 1 bit: key/IV load request.
REQ-008 Port load_ready, output, 1 bit: load accepted when load_valid and load_ready are both high on an edge.
REQ-009 Port ks_data, output, OUT_W bits: keystream word; bit 0 is the earliest keystream bit z.
REQ-010 Port ks_valid, output, 1 bit: ks_data is valid.
REQ-011 Port ks_ready, input, 1 bit: consumer accepts ks_data.
REQ-012 Port busy, output, 1 bit: high while in the INIT state.

Function
REQ-013 State s1..s288 SHALL follow eSTREAM Trivium: t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3, t1'=t1^(s91&s92)^s171, t2'=t2^(s175&s176)^s264, t3'=t3^(s286&s287)^s69; shift (s1..s93)<=(t3',s1..s92), (s94..s177)<=(t1',s94..s176), (s178..s288)<=(t2',s178..s287).
REQ-014 One state step SHALL apply REQ-013 OUT_W times combinationally (unrolled); step j yields ks bit j.
REQ-015 On load accept: s1..s80=K, s81..s93=0, s94..s173=IV, s174..s285=0, s286..s288=1, iteration counter=0.
REQ-016 FSM states are IDLE, INIT and RUN; reset enters IDLE.
REQ-017 IDLE: load_ready=1, ks_valid=0; load accept -> INIT.
REQ-018 INIT: load_ready=0; one state step per cycle, output discarded; after INIT_ROUNDS/OUT_W steps -> RUN.
REQ-019 RUN: load_ready=1; when ks_valid=0 or ks_ready=1, the block SHALL perform one step, register its OUT_W bits into ks_data and set ks_valid=1; otherwise state and ks_data SHALL hold.
REQ-020 The first ks_valid SHALL assert exactly INIT_ROUNDS/OUT_W+1 cycles after the load-accept edge, with ks_ready held high.
REQ-021 ks_data and ks_valid SHALL remain stable while ks_valid=1 and ks_ready=0.
REQ-022 A load accept in RUN (rekey) SHALL clear ks_valid on that edge and enter INIT; a ks handshake on the same edge completes (word consumed) and no further words from the old key appear.
REQ-023 load_valid in INIT SHALL be ignored, with no queuing.
REQ-024 The iteration counter width SHALL be clog2(INIT_ROUNDS/OUT_W+1); it SHALL not wrap.
REQ-025 The keystream SHALL run unbounded in RUN, with no internal limit.

Reset
REQ-026 Reset assertion SHALL immediately give state=IDLE, s=0, counter=0, ks_data=0, ks_valid=0, busy=0, load_ready=1 after deassertion.
REQ-027 Reset mid-INIT or mid-RUN SHALL abandon the operation; a new load is required before output.

Structure
REQ-028 Package trivium_pkg SHALL hold the FSM state enum, the default INIT_ROUNDS, state length 288 and the tap index constants.
REQ-029 Sub-module trivium_step (combinational, parameter OUT_W: state in, next state and OUT_W z bits out) SHALL implement REQ-013/REQ-014.

Verification
REQ-030 Scenario: OUT_W=8, load key=0, iv=0 -> busy high 144 cycles; first ks_valid on cycle 145; the word stream matches the team C golden model for the first 64 words.
REQ-031 Scenario: OUT_W=1 and OUT_W=64 with the same key/IV -> the concatenated bitstreams are identical to the OUT_W=8 run over 4096 bits.
REQ-032 Scenario: random ks_ready backpressure (50%) -> no dropped or duplicated words versus the golden model; ks_data stable while stalled.
REQ-033 Scenario: rekey in RUN with a simultaneous ks handshake -> the word is consumed, ks_valid=0 next cycle, load_ready=0 for 144 cycles, and new-key words follow.
REQ-034 Scenario: load_valid pulsed during INIT -> ignored; output equals the single-load run.
REQ-035 Scenario: rst asserted at INIT cycle 50 and at RUN word 10 -> all outputs 0 at once; no ks_valid until a new load and 145 cycles.

Source files
------------

// File: rtl/trivium_pkg.sv
// Shared constants, FSM encoding and key/IV load layout for the
// wide Trivium keystream generator.
package trivium_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } tv_state_e;

  localparam int DEF_INIT_ROUNDS = 1152;
  localparam int STATE_LEN       = 288;

  localparam int T1A = 66;
  localparam int T1B = 93;
  localparam int T1C = 91;
  localparam int T1D = 92;
  localparam int T1E = 171;
  localparam int T2A = 162;
  localparam int T2B = 177;
  localparam int T2C = 175;
  localparam int T2D = 176;
  localparam int T2E = 264;
  localparam int T3A = 243;
  localparam int T3B = 288;
  localparam int T3C = 286;
  localparam int T3D = 287;
  localparam int T3E = 69;

  // Bit i-1 of the vector holds register s(i).
  function automatic logic [STATE_LEN-1:0] load_state(
    input logic [79:0] key,
    input logic [79:0] iv
  );
    logic [STATE_LEN-1:0] s;
    s          = '0;
    s[79:0]    = key;
    s[172:93]  = iv;
    s[287:285] = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_step.sv
// OUT_W unrolled Trivium clocks; z_o[j] is the bit of the j-th clock.
module trivium_step
  import trivium_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [STATE_LEN-1:0] state_i,
  output logic [STATE_LEN-1:0] state_o,
  output logic [OUT_W-1:0]     z_o
);

  logic [STATE_LEN-1:0] st;
  logic                 t1;
  logic                 t2;
  logic                 t3;

  always_comb begin
    st  = state_i;
    z_o = '0;
    t1  = 1'b0;
    t2  = 1'b0;
    t3  = 1'b0;
    for (int j = 0; j < OUT_W; j++) begin
      t1     = st[T1A-1] ^ st[T1B-1];
      t2     = st[T2A-1] ^ st[T2B-1];
      t3     = st[T3A-1] ^ st[T3B-1];
      z_o[j] = t1 ^ t2 ^ t3;
      t1     = t1 ^ (st[T1C-1] & st[T1D-1]) ^ st[T1E-1];
      t2     = t2 ^ (st[T2C-1] & st[T2D-1]) ^ st[T2E-1];
      t3     = t3 ^ (st[T3C-1] & st[T3D-1]) ^ st[T3E-1];
      // s1/s94/s178 take t3'/t1'/t2'; each register shifts up by one.
      st = {st[286:177], t2, st[175:93], t1, st[91:0], t3};
    end
    state_o = st;
  end

endmodule

// File: rtl/trivium_wide.sv
// Trivium keystream generator: key/IV load, INIT warm-up, then
// OUT_W keystream bits per valid/ready handshake.
module trivium_wide
  import trivium_pkg::*;
#(
  parameter int OUT_W       = 8,
  parameter int INIT_ROUNDS = DEF_INIT_ROUNDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [79:0]      key_i,
  input  logic [79:0]      iv_i,
  input  logic             load_valid,
  output logic             load_ready,
  output logic [OUT_W-1:0] ks_data,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             busy
);

  localparam int STEPS = INIT_ROUNDS / OUT_W;
  localparam int CNT_W = $clog2(STEPS + 1);

  if (OUT_W < 1 || OUT_W > 64 || (INIT_ROUNDS % OUT_W) != 0)
  begin : g_bad_param
    $error("trivium_wide: OUT_W must be 1..64 and divide INIT_ROUNDS");
  end

  tv_state_e            state_q, state_d;
  logic [STATE_LEN-1:0] s_q, s_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]     ks_data_q, ks_data_d;
  logic                 ks_valid_q, ks_valid_d;

  logic [STATE_LEN-1:0] s_step;
  logic [OUT_W-1:0]     z_step;
  logic                 load_acc;

  trivium_step #(
    .OUT_W (OUT_W)
  ) u_step (
    .state_i (s_q),
    .state_o (s_step),
    .z_o     (z_step)
  );

  assign load_ready = (state_q != ST_INIT);
  assign busy       = (state_q == ST_INIT);
  assign ks_data    = ks_data_q;
  assign ks_valid   = ks_valid_q;
  assign load_acc   = load_valid & load_ready;

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    cnt_d      = cnt_q;
    ks_data_d  = ks_data_q;
    ks_valid_d = ks_valid_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (load_acc) begin
          s_d     = load_state(key_i, iv_i);
          cnt_d   = '0;
          state_d = ST_INIT;
        end
      end
      (state_q == ST_INIT): begin
        s_d   = s_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = ST_RUN;
        end
      end
      (state_q == ST_RUN): begin
        // Rekey wins; any same-edge handshake simply retires the word.
        if (load_acc) begin
          s_d        = load_state(key_i, iv_i);
          cnt_d      = '0;
          ks_valid_d = 1'b0;
          state_d    = ST_INIT;
        end else if (!ks_valid_q || ks_ready) begin
          s_d        = s_step;
          ks_data_d  = z_step;
          ks_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      cnt_q      <= '0;
      ks_data_q  <= '0;
      ks_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      ks_data_q  <= ks_data_d;
      ks_valid_q <= ks_valid_d;
    end
  end

endmodule

// File: tb/tb_trivium_wide.sv
// Directed bench: bit-serial Trivium reference, three output widths,
// backpressure, rekey, ignored reload and mid-operation reset.
module tb_trivium_wide;

  localparam logic [79:0] KEY_A = 80'h0;
  localparam logic [79:0] IV_A  = 80'h0;
  localparam logic [79:0] KEY_B = 80'h0123456789abcdef0123;
  localparam logic [79:0] IV_B  = 80'hfedcba9876543210fedc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [79:0] key = '0;
  logic [79:0] iv  = '0;
  logic        lv  = 1'b0;

  logic        r8 = 1'b0, r64 = 1'b0, r1 = 1'b0;
  logic        lr8, lr64, lr1;
  logic        v8, v64, v1;
  logic        busy8, busy64, busy1;
  logic [7:0]  d8;
  logic [63:0] d64;
  logic [0:0]  d1;

  int total = 0;
  int bad   = 0;

  bit ms [1:288];
  bit exp_bits [2][4096];

  int  idx8 = 0, idx64 = 0, idx1 = 0;
  int  sel8 = 0;
  bit  en8 = 1'b1, en64 = 1'b1, en1 = 1'b1;

  always #5 clk = ~clk;

  trivium_wide #(.OUT_W(8)) u8 (
    .clk(clk), .rst(rst), .key_i(key), .iv_i(iv),
    .load_valid(lv), .load_ready(lr8), .ks_data(d8),
    .ks_valid(v8), .ks_ready(r8), .busy(busy8)
  );

  trivium_wide #(.OUT_W(64)) u64 (
    .clk(clk), .rst(rst), .key_i(key), .iv_i(iv),
    .load_valid(lv), .load_ready(lr64), .ks_data(d64),
    .ks_valid(v64), .ks_ready(r64), .busy(busy64)
  );

  trivium_wide #(.OUT_W(1)) u1 (
    .clk(clk), .rst(rst), .key_i(key), .iv_i(iv),
    .load_valid(lv), .load_ready(lr1), .ks_data(d1),
    .ks_valid(v1), .ks_ready(r1), .busy(busy1)
  );

  task automatic mload(input logic [79:0] k, input logic [79:0] v);
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) ms[i] = k[i-1];
    for (int i = 1; i <= 80; i++) ms[93+i] = v[i-1];
    ms[286] = 1'b1;
    ms[287] = 1'b1;
    ms[288] = 1'b1;
  endtask

  task automatic mstep(output bit z);
    bit a, b, c;
    a = ms[66] ^ ms[93];
    b = ms[162] ^ ms[177];
    c = ms[243] ^ ms[288];
    z = a ^ b ^ c;
    a = a ^ (ms[91] & ms[92]) ^ ms[171];
    b = b ^ (ms[175] & ms[176]) ^ ms[264];
    c = c ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
    ms[178] = b;
    for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
    ms[94] = a;
    for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
    ms[1] = c;
  endtask

  task automatic gen(input int s, input logic [79:0] k,
                     input logic [79:0] v);
    bit z;
    mload(k, v);
    for (int i = 0; i < 1152; i++) mstep(z);
    for (int i = 0; i < 4096; i++) begin
      mstep(z);
      exp_bits[s][i] = z;
    end
  endtask

  function automatic logic [63:0] expw(input int s, input int base,
                                       input int w);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < w; j++) r[j] = exp_bits[s][base+j];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  task automatic score();
    if (en8 && v8 && r8 && idx8 < 512) begin
      chk($sformatf("ks8[%0d]", idx8), 64'(d8),
          64'(8'(expw(sel8, idx8 * 8, 8))));
      idx8++;
    end
    if (en64 && v64 && r64 && idx64 < 64) begin
      chk($sformatf("ks64[%0d]", idx64), d64, expw(0, idx64 * 64, 64));
      idx64++;
    end
    if (en1 && v1 && r1 && idx1 < 4096) begin
      chk($sformatf("ks1[%0d]", idx1), 64'(d1),
          64'(1'(expw(0, idx1, 1))));
      idx1++;
    end
  endtask

  task automatic cyc();
    logic pv, pr, pl;
    logic [7:0] pd;
    score();
    pv = v8;
    pr = r8;
    pd = d8;
    pl = lv && lr8;
    @(posedge clk);
    #1;
    if (pv && !pr && !pl && rst) begin
      chk("stall_hold", {55'd0, v8, d8}, {55'd0, 1'b1, pd});
    end
  endtask

  task automatic load(input logic [79:0] k, input logic [79:0] v);
    key = k;
    iv  = v;
    lv  = 1'b1;
    r8  = 1'b0;
    r64 = 1'b0;
    r1  = 1'b0;
    cyc();
    lv  = 1'b0;
  endtask

  task automatic run8(input int words, input int lim, input bit rnd,
                      output int first, output int bc);
    first = -1;
    bc    = 0;
    for (int n = 0; n < lim && idx8 < words; n++) begin
      if (v8 && first < 0) first = n;
      if (busy8) bc++;
      r8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
    end
    chk("run8_words", 64'(idx8 >= words), 64'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, 64'(v8), 64'd0);
    chk({tag, "_data"}, 64'(d8), 64'd0);
    chk({tag, "_busy"}, 64'(busy8), 64'd0);
    chk({tag, "_ready"}, 64'(lr8), 64'd1);
  endtask

  initial begin
    int f8, f64, f1, bc8, f, b, cnt;

    gen(0, KEY_A, IV_A);
    gen(1, KEY_B, IV_B);

    #1;
    chk_reset_outs("por");
    chk("por_v64", 64'(v64), 64'd0);
    chk("por_d64", d64, 64'd0);
    #20;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // All three widths from one key/IV, full 4096-bit streams
    load(KEY_A, IV_A);
    f8 = -1; f64 = -1; f1 = -1; bc8 = 0;
    for (int n = 0; n < 5600; n++) begin
      if (idx8 >= 512 && idx64 >= 64 && idx1 >= 4096) break;
      if (v8 && f8 < 0) f8 = n;
      if (v64 && f64 < 0) f64 = n;
      if (v1 && f1 < 0) f1 = n;
      if (busy8) bc8++;
      r8  = (idx8 < 512);
      r64 = (idx64 < 64);
      r1  = (idx1 < 4096);
      cyc();
    end
    chk("first_valid_w8", 64'(f8), 64'd145);
    chk("first_valid_w64", 64'(f64), 64'd19);
    chk("first_valid_w1", 64'(f1), 64'd1153);
    chk("busy_cycles_w8", 64'(bc8), 64'd144);
    chk("stream_done", 64'(idx8 + idx64 + idx1), 64'(512 + 64 + 4096));
    en64 = 1'b0;
    en1  = 1'b0;

    // Random backpressure
    idx8 = 0;
    sel8 = 0;
    load(KEY_A, IV_A);
    run8(64, 3000, 1'b1, f, b);

    // Rekey with a same-edge handshake
    r8 = 1'b0;
    for (int n = 0; n < 10 && !v8; n++) cyc();
    chk("pre_rekey_valid", 64'(v8), 64'd1);
    key = KEY_B;
    iv  = IV_B;
    lv  = 1'b1;
    r8  = 1'b1;
    cnt = idx8;
    cyc();
    lv = 1'b0;
    chk("rekey_consumed", 64'(idx8), 64'(cnt + 1));
    chk("rekey_valid", 64'(v8), 64'd0);
    chk("rekey_ready", 64'(lr8), 64'd0);
    sel8 = 1;
    idx8 = 0;
    run8(16, 400, 1'b0, f, b);
    chk("rekey_first", 64'(f), 64'd145);
    chk("rekey_busy", 64'(b), 64'd144);

    // load_valid pulse during INIT is ignored
    sel8 = 0;
    idx8 = 0;
    load(KEY_A, IV_A);
    r8 = 1'b1;
    for (int n = 0; n < 20; n++) cyc();
    chk("init_ready", 64'(lr8), 64'd0);
    key = KEY_B;
    iv  = IV_B;
    lv  = 1'b1;
    cyc();
    lv = 1'b0;
    run8(16, 400, 1'b0, f, b);
    chk("ignored_first", 64'(f), 64'd124);
    chk("ignored_busy", 64'(b), 64'd123);

    // Reset at INIT cycle 50
    idx8 = 0;
    load(KEY_A, IV_A);
    r8 = 1'b1;
    for (int n = 0; n < 49; n++) cyc();
    chk("pre_rst_busy", 64'(busy8), 64'd1);
    rst = 1'b0;
    #1;
    chk_reset_outs("rst_init");
    #1;
    rst = 1'b1;
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      if (v8) cnt++;
      cyc();
    end
    chk("rst_init_quiet", 64'(cnt), 64'd0);

    // Reset at RUN word 10
    idx8 = 0;
    load(KEY_A, IV_A);
    run8(10, 400, 1'b0, f, b);
    chk("pre_rst_valid", 64'(v8), 64'd1);
    rst = 1'b0;
    #1;
    chk_reset_outs("rst_run");
    #1;
    rst = 1'b1;
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      if (v8) cnt++;
      cyc();
    end
    chk("rst_run_quiet", 64'(cnt), 64'd0);
    idx8 = 0;
    load(KEY_A, IV_A);
    run8(4, 400, 1'b0, f, b);
    chk("reload_first", 64'(f), 64'd145);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
